// File: rtl/gate_truth_seq.sv
// Purpose: sweeps {gate_a,gate_b} through 00,01,10,11 and compares gate_y against EXPECTED.
// Latency: start accepted at edge E0 -> done pulse after edge E0+4*HOLD_CYCLES; results are held until the next sweep.
// Backpressure: none. start is ignored while a sweep runs. abort cancels the sweep without reporting.
// Ports: clk, rst_n (async, active low); start/abort control; gate_a/gate_b drive the gate under test;
//        gate_y is its output; busy/done/pass/fail_mask report status.
// Optional: define GATE_SEQ_ERRLOG_EN to add err_valid/err_vec, which capture the first failing vector.
module gate_truth_seq #(
  parameter int         HOLD_CYCLES = 4,
  parameter logic [3:0] EXPECTED    = 4'b0111
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic       gate_a,
  output logic       gate_b,
  input  logic       gate_y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_mask
`ifdef GATE_SEQ_ERRLOG_EN
  ,
  output logic       err_valid,
  output logic [1:0] err_vec
`endif
);

  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

  localparam logic [7:0] LAST = 8'(HOLD_CYCLES - 1);

  state_t     state, state_nxt;
  logic [1:0] idx, idx_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic [3:0] mask, mask_nxt;
  logic       mism;

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    mask_nxt  = mask;
    mism      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = DRIVE;
          idx_nxt   = 2'd0;
          cnt_nxt   = 8'd0;
          mask_nxt  = 4'd0;
        end
      end
      DRIVE: begin
        // abort wins over a sample landing on the same edge
        if (abort) begin
          state_nxt = IDLE;
          idx_nxt   = 2'd0;
          cnt_nxt   = 8'd0;
        end else if (cnt == LAST) begin
          // case inequality so an X/Z gate output is treated as a mismatch
          mism     = (gate_y !== EXPECTED[idx]);
          mask_nxt = mask | (4'(mism) << idx);
          cnt_nxt  = 8'd0;
          if (idx == 2'd3) begin
            state_nxt = DONE;
            idx_nxt   = 2'd0;
          end else begin
            idx_nxt = idx + 2'd1;
          end
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = 2'd0;
        cnt_nxt   = 8'd0;
      end
    endcase
  end

  // Outputs are flopped from the next-state values so they line up with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= 2'd0;
      cnt       <= 8'd0;
      mask      <= 4'd0;
      gate_a    <= 1'b0;
      gate_b    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_mask <= 4'd0;
    end else begin
      state  <= state_nxt;
      idx    <= idx_nxt;
      cnt    <= cnt_nxt;
      mask   <= mask_nxt;
      gate_a <= (state_nxt == DRIVE) && idx_nxt[1];
      gate_b <= (state_nxt == DRIVE) && idx_nxt[0];
      busy   <= (state_nxt == DRIVE);
      done   <= (state_nxt == DONE);
      if ((state == DRIVE) && (state_nxt == DONE)) begin
        fail_mask <= mask_nxt;
        pass      <= (mask_nxt == 4'd0);
      end
    end
  end

`ifdef GATE_SEQ_ERRLOG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_valid <= 1'b0;
      err_vec   <= 2'd0;
    end else if ((state == IDLE) && start) begin
      err_valid <= 1'b0;
      err_vec   <= 2'd0;
    end else if (mism && !err_valid) begin
      err_valid <= 1'b1;
      err_vec   <= idx;
    end
  end
`endif

endmodule

// File: tb/tb_gate_truth_seq.sv
// Bench for gate_truth_seq: three instances (NAND H=4, NAND H=1, XOR H=3), each driving a modelled gate.
// Expected results come from a truth-table model: mismatch bit v = (gate output for vector v) !== EXPECTED[v].
module tb_gate_truth_seq;

  localparam logic [2:0][7:0] HCV  = {8'd3, 8'd1, 8'd4};
  localparam logic [2:0][3:0] EXPV = {4'b0110, 4'b0111, 4'b0111};

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] start, abort, gate_a, gate_b, gate_y, busy, done, pass;
  logic [3:0] fail_mask [3];
`ifdef GATE_SEQ_ERRLOG_EN
  logic [2:0] err_valid;
  logic [1:0] err_vec [3];
`endif

  logic [3:0] tt [3];   // truth table of each gate under test
  logic [3:0] xm [3];   // vectors on which that gate drives X
  logic       xbit;
  logic       last_pass [3];
  logic [3:0] last_mask [3];
  int         tests = 0;
  int         fails = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign gate_y[g] = xm[g][{gate_a[g], gate_b[g]}] ? xbit : tt[g][{gate_a[g], gate_b[g]}];
    gate_truth_seq #(.HOLD_CYCLES(int'(HCV[g])), .EXPECTED(EXPV[g])) u_dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start[g]),
      .abort(abort[g]),
      .gate_a(gate_a[g]),
      .gate_b(gate_b[g]),
      .gate_y(gate_y[g]),
      .busy(busy[g]),
      .done(done[g]),
      .pass(pass[g]),
      .fail_mask(fail_mask[g])
`ifdef GATE_SEQ_ERRLOG_EN
      ,
      .err_valid(err_valid[g]),
      .err_vec(err_vec[g])
`endif
    );
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] model_mask(input int g, input logic [3:0] t, input logic [3:0] x);
    logic [3:0] m;
    logic       y;
    m = 4'd0;
    for (int v = 0; v < 4; v++) begin
      y    = x[v] ? xbit : t[v];
      m[v] = (y !== EXPV[g][v]);
    end
    return m;
  endfunction

  task automatic chk_zero(input int g);
    chk("rst_busy", 8'(busy[g]), 8'd0);
    chk("rst_done", 8'(done[g]), 8'd0);
    chk("rst_pass", 8'(pass[g]), 8'd0);
    chk("rst_mask", 8'(fail_mask[g]), 8'd0);
    chk("rst_ab", 8'({gate_a[g], gate_b[g]}), 8'd0);
`ifdef GATE_SEQ_ERRLOG_EN
    chk("rst_errv", 8'(err_valid[g]), 8'd0);
    chk("rst_errvec", 8'(err_vec[g]), 8'd0);
`endif
  endtask

  // Full sweep; entered and left at #1 after a rising edge (or at a falling edge).
  task automatic sweep(input int g, input logic [3:0] t, input logic [3:0] x, input bit pokes);
    int         h;
    int         first;
    logic [3:0] em;
    h     = int'(HCV[g]);
    tt[g] = t;
    xm[g] = x;
    em    = model_mask(g, t, x);
    start[g] = 1'b1;
    @(posedge clk); #1;
    start[g] = 1'b0;
    for (int k = 0; k < 4 * h; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      chk("drv_busy", 8'(busy[g]), 8'd1);
      chk("drv_ab", 8'({gate_a[g], gate_b[g]}), 8'(k / h));
      chk("drv_done", 8'(done[g]), 8'd0);
      start[g] = pokes && ($urandom_range(0, 3) == 0);
    end
    @(posedge clk); #1;
    start[g] = 1'b0;
    chk("done_pulse", 8'(done[g]), 8'd1);
    chk("done_busy", 8'(busy[g]), 8'd0);
    chk("done_ab", 8'({gate_a[g], gate_b[g]}), 8'd0);
    chk("fail_mask", 8'(fail_mask[g]), 8'(em));
    chk("pass", 8'(pass[g]), 8'(em == 4'd0));
`ifdef GATE_SEQ_ERRLOG_EN
    first = 0;
    for (int v = 3; v >= 0; v--) if (em[v]) first = v;
    chk("err_valid", 8'(err_valid[g]), 8'(em != 4'd0));
    if (em != 4'd0) chk("err_vec", 8'(err_vec[g]), 8'(first));
`else
    first = 0;
`endif
    last_pass[g] = (em == 4'd0);
    last_mask[g] = em;
    abort[g] = pokes && ($urandom_range(0, 1) == 0);   // abort seen in DONE must be ignored
    @(posedge clk); #1;
    abort[g] = 1'b0;
    chk("post_done", 8'(done[g]), 8'd0);
    chk("post_busy", 8'(busy[g]), 8'd0);
    chk("hold_mask", 8'(fail_mask[g]), 8'(em));
    chk("hold_pass", 8'(pass[g]), 8'(em == 4'd0));
  endtask

  // Sweep cut short after the check at start edge + cut, by abort or by reset.
  task automatic sweep_cut(input int g, input logic [3:0] t, input logic [3:0] x, input int cut,
                           input bit by_reset);
    int h;
    h     = int'(HCV[g]);
    tt[g] = t;
    xm[g] = x;
    start[g] = 1'b1;
    @(posedge clk); #1;
    start[g] = 1'b0;
    for (int k = 0; k <= cut; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      chk("cut_busy", 8'(busy[g]), 8'd1);
      chk("cut_ab", 8'({gate_a[g], gate_b[g]}), 8'(k / h));
      start[g] = (k < cut) && ($urandom_range(0, 2) == 0);
    end
    start[g] = 1'b0;
    if (!by_reset) begin
      abort[g] = 1'b1;
      @(posedge clk); #1;
      abort[g] = 1'b0;
      for (int c = 0; c < 3; c++) begin
        if (c > 0) begin
          @(posedge clk); #1;
        end
        chk("abt_busy", 8'(busy[g]), 8'd0);
        chk("abt_done", 8'(done[g]), 8'd0);
        chk("abt_ab", 8'({gate_a[g], gate_b[g]}), 8'd0);
        chk("abt_pass", 8'(pass[g]), 8'(last_pass[g]));
        chk("abt_mask", 8'(fail_mask[g]), 8'(last_mask[g]));
      end
    end else begin
      #2 rst_n = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
        chk_zero(i);
        last_pass[i] = 1'b0;
        last_mask[i] = 4'd0;
      end
      repeat (2) begin
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) chk("rst_nodone", 8'(done[i]), 8'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;
    end
  endtask

  initial begin
    int g;
    int h;
    int mode;
    xbit  = 1'bx;
    rst_n = 1'b0;
    start = 3'b000;
    abort = 3'b000;
    for (int i = 0; i < 3; i++) begin
      tt[i]        = EXPV[i];
      xm[i]        = 4'd0;
      last_pass[i] = 1'b0;
      last_mask[i] = 4'd0;
    end
    #12;
    for (int i = 0; i < 3; i++) chk_zero(i);
    @(negedge clk);
    rst_n = 1'b1;

    // first edge after reset release accepts start
    sweep(0, 4'b0111, 4'b0000, 1'b0);           // correct NAND
    sweep(0, 4'b1111, 4'b0000, 1'b0);           // stuck-at-1
    sweep(1, 4'b0000, 4'b0000, 1'b0);           // stuck-at-0, H=1
    sweep(2, 4'b0110, 4'b0001, 1'b0);           // XOR with X on vector 0
    sweep(0, 4'b0111, 4'b0000, 1'b1);           // passing sweep, then abort in vector 2
    sweep_cut(0, 4'b0111, 4'b0000, 9, 1'b0);
    sweep_cut(0, 4'b0111, 4'b0000, 6, 1'b1);    // reset during vector 1
    sweep(0, 4'b0111, 4'b0000, 1'b1);

    // abort while idle does nothing
    abort = 3'b111;
    repeat (2) @(posedge clk);
    #1;
    abort = 3'b000;
    for (int i = 0; i < 3; i++) begin
      chk("idle_abt_busy", 8'(busy[i]), 8'd0);
      chk("idle_abt_mask", 8'(fail_mask[i]), 8'(last_mask[i]));
    end

    for (int n = 0; n < 40; n++) begin
      g    = $urandom_range(0, 2);
      h    = int'(HCV[g]);
      mode = $urandom_range(0, 5);
      if (mode == 0)
        sweep_cut(g, 4'($urandom), ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0,
                  $urandom_range(0, 4 * h - 1), 1'b0);
      else if (mode == 1)
        sweep_cut(g, 4'($urandom), 4'd0, $urandom_range(0, 4 * h - 1), 1'b1);
      else
        sweep(g, 4'($urandom), ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
